udp_pkt_buffer: RTL and testbench
=================================

UDP_PKT_BUFFER -- requirements
Module: udp_pkt_buffer

Interface
REQ-001 SHALL have parameter PKT_LEN, default 16'd1024, meaning the payload byte count that triggers a full packet.
REQ-002 SHALL have parameter DEPTH, default 2048, meaning FIFO depth in bytes; power of 2, DEPTH >= PKT_LEN.
REQ-003 SHALL have port I_clk50m, input, 1, the 50 MHz clock for all logic.
REQ-004 SHALL have port I_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port I_wr_en, input, 1, write strobe for one payload byte.
REQ-006 SHALL have port I_wr_data, input, 8, payload byte.
REQ-007 SHALL have port I_flush, input, 1, single-cycle request to send a partial packet.
REQ-008 SHALL have port O_full, output, 1, high when FIFO occupancy == DEPTH.
REQ-009 SHALL have port O_mac_en, output, 1, packet start request to the MAC transmitter.
REQ-010 SHALL have port O_mac_data, output, 8, current payload byte presented to the MAC.
REQ-011 SHALL have port O_mac_udpLen, output, 16, UDP length field = payload bytes + 8.
REQ-012 SHALL have port I_mac_busy, input, 1, MAC frame in progress.
REQ-013 SHALL have port I_mac_load, input, 1, one-cycle pulse: MAC sampled O_mac_data this cycle.

Function
REQ-014 SHALL store written bytes in a DEPTH x 8 circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-015 SHALL drop a write while O_full is high, leaving FIFO contents and occupancy unchanged.
REQ-016 SHALL, on the same cycle as a write and a pop, apply both and leave occupancy unchanged.
REQ-017 SHALL implement states IDLE, START, SEND, DONE.
REQ-018 IDLE: when occupancy >= PKT_LEN, SHALL latch len = PKT_LEN and go to START.
REQ-019 IDLE: when flush is pending and 0 < occupancy < PKT_LEN, SHALL latch len = occupancy and go to START.
REQ-020 IDLE: when flush is pending and occupancy == 0, SHALL clear the flush and stay in IDLE.
REQ-021 SHALL record an I_flush pulse as pending in any state and clear it when a packet is launched from IDLE.
REQ-022 SHALL hold O_mac_udpLen = len + 8 from entry into START until return to IDLE.
REQ-023 START: SHALL assert O_mac_en, keep it high until I_mac_busy is sampled high, then deassert O_mac_en and go to SEND.
REQ-024 SHALL present the FIFO head byte on O_mac_data first-word-fall-through, valid from START entry.
REQ-025 SEND: on each I_mac_load, SHALL pop one byte, decrement remaining, and show the next byte on O_mac_data the following cycle.
REQ-026 SHALL ignore I_mac_load when remaining == 0 and drive O_mac_data = 8'h00 as pad.
REQ-027 SEND: when remaining reaches 0, SHALL go to DONE.
REQ-028 SHALL go to DONE if I_mac_busy falls while in SEND, with any unpopped bytes kept in the FIFO.
REQ-029 DONE: SHALL wait for I_mac_busy low, then go to IDLE.
REQ-030 SHALL accept writes in every state.

Reset
REQ-031 While I_rst is low, SHALL immediately force state IDLE, pointers 0, occupancy 0, flush pending 0.
REQ-032 While I_rst is low, SHALL force O_mac_en 0, O_mac_data 8'h00, O_mac_udpLen 16'd0, O_full 0.
REQ-033 SHALL discard all buffered data on reset mid-packet, with no further load response.

Configuration
REQ-034 With macro UDP_PKT_BUF_DROPCNT_EN defined, SHALL add output O_drop_cnt (16 bits), the count of dropped writes, saturating at 16'hFFFF and reset to 0.
REQ-035 Without UDP_PKT_BUF_DROPCNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Write 1024 bytes 0x00..0xFF repeating, MAC model loads every 4 cycles -> O_mac_en rises, O_mac_udpLen = 1032, 1024 bytes out in order, state returns to IDLE.
REQ-037 Write 10 bytes, pulse I_flush -> packet with O_mac_udpLen = 18 and exactly 10 bytes; loads 11..18 return 0x00.
REQ-038 With the MAC model held busy, write DEPTH+5 bytes -> O_full high after DEPTH writes, 5 writes dropped, O_drop_cnt = 5 when macro defined.
REQ-039 Pulse I_flush with an empty FIFO -> no O_mac_en, flush cleared.
REQ-040 Assert I_rst after 300 of 1024 bytes are loaded -> all outputs at reset values same cycle; next 1024 writes produce a clean packet.
REQ-041 Write continuously during SEND at one byte per cycle -> second packet launches immediately after DONE, no byte lost or duplicated.

Source files
------------

// File: rtl/udp_pkt_buffer.sv
// UDP payload FIFO that frames bytes into packets for the MAC transmitter.
// Optional drop counter port enabled by macro UDP_PKT_BUF_DROPCNT_EN.
module udp_pkt_buffer #(
  parameter logic [15:0] PKT_LEN = 16'd1024,
  parameter int          DEPTH   = 2048
) (
  input  logic        I_clk50m,
  input  logic        I_rst,
  input  logic        I_wr_en,
  input  logic [7:0]  I_wr_data,
  input  logic        I_flush,
  output logic        O_full,
  output logic        O_mac_en,
  output logic [7:0]  O_mac_data,
  output logic [15:0] O_mac_udpLen,
  input  logic        I_mac_busy,
  input  logic        I_mac_load
`ifdef UDP_PKT_BUF_DROPCNT_EN
  ,
  output logic [15:0] O_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    st_q, st_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rem_q, rem_d;
  logic          flush_q, flush_d;
  logic          wr_ok;
  logic          pop;
  logic          pkt_ready;
  logic          part_ready;

  assign O_full = (cnt_q == CW'(DEPTH));
  assign wr_ok  = I_wr_en && !O_full;
  assign pop    = (st_q == S_SEND) && I_mac_load
               && (rem_q != 16'd0);

  assign pkt_ready  = 32'(cnt_q) >= 32'(PKT_LEN);
  assign part_ready = flush_q && (cnt_q != '0);

  always_ff @(posedge I_clk50m) begin
    if (wr_ok) mem_q[wptr_q] <= I_wr_data;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    len_d   = len_q;
    rem_d   = rem_q;
    flush_d = flush_q | I_flush;
    unique case (st_q)
      S_IDLE: begin
        if (pkt_ready) begin
          len_d   = PKT_LEN;
          rem_d   = PKT_LEN;
          st_d    = S_START;
          flush_d = I_flush;
        end else if (part_ready) begin
          len_d   = 16'(cnt_q);
          rem_d   = 16'(cnt_q);
          st_d    = S_START;
          flush_d = I_flush;
        end else if (flush_q) begin
          flush_d = I_flush;
        end
      end
      S_START: begin
        if (I_mac_busy) st_d = S_SEND;
      end
      S_SEND: begin
        if (pop) rem_d = rem_q - 1'b1;
        // MAC aborting the frame leaves unsent bytes queued
        if (!I_mac_busy || (pop && rem_q == 16'd1))
          st_d = S_DONE;
      end
      S_DONE: begin
        if (!I_mac_busy) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      st_q    <= S_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      flush_q <= flush_d;
    end
  end

  assign O_mac_en = (st_q == S_START);

  assign O_mac_udpLen = (st_q == S_IDLE)
                      ? 16'd0 : len_q + 16'd8;

  // Pad with zeros once the payload is exhausted
  assign O_mac_data = ((st_q == S_START || st_q == S_SEND)
                       && rem_q != 16'd0)
                    ? mem_q[rptr_q] : 8'h00;

`ifdef UDP_PKT_BUF_DROPCNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst)
      drop_q <= '0;
    else if (I_wr_en && O_full && drop_q != 16'hFFFF)
      drop_q <= drop_q + 1'b1;
  end

  assign O_drop_cnt = drop_q;
`else
  // No drop counter in this build
`endif

endmodule

// File: tb/tb_udp_pkt_buffer.sv
// Randomized bench for udp_pkt_buffer with a queue-based packet model
// and a simple MAC responder.
module tb_udp_pkt_buffer;

  localparam int DEPTH = 2048;
  localparam int PKT   = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        busy = 1'b0;
  logic        load = 1'b0;
  logic        full;
  logic        mac_en;
  logic [7:0]  mac_data;
  logic [15:0] udp_len;
`ifdef UDP_PKT_BUF_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  always #10 clk = ~clk;

  udp_pkt_buffer #(
    .PKT_LEN(16'(PKT)),
    .DEPTH  (DEPTH)
  ) dut (
    .I_clk50m    (clk),
    .I_rst       (rst_n),
    .I_wr_en     (wr_en),
    .I_wr_data   (wr_data),
    .I_flush     (flush),
    .O_full      (full),
    .O_mac_en    (mac_en),
    .O_mac_data  (mac_data),
    .O_mac_udpLen(udp_len),
    .I_mac_busy  (busy),
    .I_mac_load  (load)
`ifdef UDP_PKT_BUF_DROPCNT_EN
    ,
    .O_drop_cnt  (drop_cnt)
`endif
  );

  int errs = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 requesting, 2 sending, 3 finishing
  logic [7:0] mq[$];
  int m_ph, m_len, m_rem, m_drops;
  bit m_fl;

  bit         s_wr, s_fl;
  logic [7:0] s_data;

  int mac_ph, mac_dly, mac_gap, mac_per, mac_n, mac_tgt;
  bit mac_hold;
  logic [7:0] cap[$];
  int pkt_cnt = 0;
  int pkt_udp = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
      if (errs >= 200) begin
        $display("Result: errors=%0d of %0d checks",
                 errs, checks);
        $finish;
      end
    end
  endtask

  task automatic cycle();
    bit wr_ok, pop;
    int sz;
    @(negedge clk);
    chk("mac_en", mac_en, m_ph == 1);
    chk("udp_len", udp_len, m_ph == 0 ? 0 : m_len + 8);
    chk("mac_data", mac_data,
        ((m_ph == 1 || m_ph == 2) && m_rem != 0) ? mq[0] : 0);
    chk("full", full, mq.size() == DEPTH);
`ifdef UDP_PKT_BUF_DROPCNT_EN
    chk("drop_cnt", drop_cnt, m_drops);
`endif
    load = 1'b0;
    if (mac_hold) begin
      busy = 1'b1;
    end else begin
      case (mac_ph)
        0: if (mac_en) begin
          mac_ph  = 1;
          mac_dly = $urandom_range(0, 2);
          mac_tgt = udp_len;
          pkt_udp = udp_len;
          pkt_cnt++;
          mac_n   = 0;
          mac_gap = 0;
          cap.delete();
        end
        1: if (mac_dly == 0) begin
          busy   = 1'b1;
          mac_ph = 2;
        end else mac_dly--;
        default: begin
          if (mac_n >= mac_tgt) begin
            busy   = 1'b0;
            mac_ph = 0;
          end else if (mac_gap == mac_per - 1) begin
            load = 1'b1;
            cap.push_back(mac_data);
            mac_n++;
            mac_gap = 0;
          end else mac_gap++;
        end
      endcase
    end
    wr_en   = s_wr;
    wr_data = s_data;
    flush   = s_fl;
    sz    = mq.size();
    wr_ok = s_wr && sz < DEPTH;
    if (s_wr && !wr_ok && m_drops < 65535) m_drops++;
    pop = (m_ph == 2) && load && m_rem != 0;
    case (m_ph)
      0: begin
        if (sz >= PKT) begin
          m_len = PKT; m_rem = PKT; m_ph = 1;
        end else if (m_fl && sz > 0) begin
          m_len = sz; m_rem = sz; m_ph = 1;
        end
        m_fl = 0;
      end
      1: if (busy) m_ph = 2;
      2: begin
        if (pop) m_rem--;
        if (!busy || m_rem == 0) m_ph = 3;
      end
      default: if (!busy) m_ph = 0;
    endcase
    m_fl = m_fl | s_fl;
    if (pop) void'(mq.pop_front());
    if (wr_ok) mq.push_back(s_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy  = 1'b0;
    load  = 1'b0;
    wr_en = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_data", mac_data, 0);
    chk("rst_udp_len", udp_len, 0);
    chk("rst_full", full, 0);
`ifdef UDP_PKT_BUF_DROPCNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    mq.delete();
    m_ph = 0; m_len = 0; m_rem = 0; m_drops = 0; m_fl = 0;
    mac_ph = 0; mac_n = 0;
    s_wr = 0; s_fl = 0; s_data = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr_burst(int n, bit inc, int base);
    for (int i = 0; i < n; i++) begin
      s_wr   = 1;
      s_data = inc ? 8'(base + i) : 8'($urandom);
      cycle();
    end
    s_wr = 0;
  endtask

  task automatic drain(string nm, int budget);
    int k = 0;
    while (!(m_ph == 0 && mac_ph == 0 && !busy && !m_fl
             && mq.size() < PKT) && k < budget) begin
      cycle();
      k++;
    end
    chk(nm, k < budget, 1);
  endtask

  task automatic pulse_flush();
    s_fl = 1;
    cycle();
    s_fl = 0;
  endtask

  task automatic chk_pkt(string nm, int len, int base);
    int bad = 0;
    chk({nm, "_udp"}, pkt_udp, len + 8);
    chk({nm, "_loads"}, cap.size(), len + 8);
    for (int i = 0; i < cap.size(); i++)
      if (cap[i] !== (i < len ? 8'(base + i) : 8'h00)) bad++;
    chk({nm, "_bytes"}, bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $display("Result: errors=%0d of %0d checks",
             errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, k;
    mac_per  = 4;
    mac_hold = 0;
    do_reset();

    // Full 1024-byte packet, MAC loading every 4 cycles
    wr_burst(PKT, 1, 0);
    drain("pkt1_drain", 8000);
    chk("pkt1_count", pkt_cnt, 1);
    chk_pkt("pkt1", PKT, 0);

    // Partial packet via flush
    wr_burst(10, 1, 8'hA0);
    pulse_flush();
    drain("flush_drain", 500);
    chk("flush_count", pkt_cnt, 2);
    chk_pkt("flush", 10, 8'hA0);

    // Flush with empty FIFO must not launch or stay pending
    pc = pkt_cnt;
    pulse_flush();
    repeat (10) cycle();
    wr_burst(5, 1, 8'h30);
    repeat (30) cycle();
    chk("empty_flush_nolaunch", pkt_cnt, pc);
    pulse_flush();
    drain("flush5_drain", 500);
    chk_pkt("flush5", 5, 8'h30);

    // Continuous random writes while sending
    mac_per = 1;
    pc = pkt_cnt;
    for (int i = 0; i < 2600; i++) begin
      s_wr   = ($urandom_range(0, 7) != 0);
      s_data = 8'($urandom);
      s_fl   = ($urandom_range(0, 999) == 0);
      cycle();
    end
    s_wr = 0; s_fl = 0;
    drain("stream_drain", 6000);
    pulse_flush();
    drain("stream_tail", 3000);
    chk("stream_pkts", pkt_cnt - pc >= 2, 1);
    chk("stream_empty", mq.size(), 0);

    // Reset in the middle of a packet
    mac_per = 2;
    wr_burst(PKT, 1, 0);
    k = 0;
    while (!(mac_ph == 2 && mac_n >= 300) && k < 4000) begin
      cycle();
      k++;
    end
    chk("mid_pkt_reach", k < 4000, 1);
    do_reset();
    pc = pkt_cnt;
    wr_burst(PKT, 1, 8'h55);
    drain("post_rst_drain", 4000);
    chk("post_rst_count", pkt_cnt, pc + 1);
    chk_pkt("post_rst", PKT, 8'h55);

    // MAC held busy: fill to DEPTH and overflow by 5
    mac_hold = 1;
    wr_burst(DEPTH - 1, 0, 0);
    cycle();
    chk("not_full_depth_m1", full, 0);
    wr_burst(6, 0, 0);
    cycle();
    chk("full_at_depth", full, 1);
    chk("drops_model", m_drops, 5);
`ifdef UDP_PKT_BUF_DROPCNT_EN
    chk("drop_cnt_5", drop_cnt, 5);
`endif
    mac_hold = 0;
    do_reset();
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
